// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage-state encoding and
// default bundle widths for the inter-stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam int PC_W      = 32;
  localparam int REG_NUM_W = 5;
  localparam int S_DATA_W  = 2;

  // pc + b + c + num_write + control
  localparam int EXE_MEM_W =
    3 * PC_W + REG_NUM_W + 2 * S_DATA_W;

endpackage

// File: rtl/pipe_slot.sv
// Single valid+data register with load/clear/hold.
// Ports: clock, reset, load, clear, d -> valid, q (zero when clear).
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXE_MEM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  // clear beats load so a bubble is always all-zero
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register, optional 2-entry skid.
// Ports: clock, reset, flush, in_valid/in_ready/in_data,
// out_valid/out_ready/out_data, stall_cnt (saturating).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXE_MEM_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic push;
  logic pop;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      stage_state_e      state;
      stage_state_e      nxt;
      logic              rdy_q;
      logic              m_load;
      logic              m_clr;
      logic              m_from_skid;
      logic              s_load;
      logic              s_clr;
      logic              s_valid;
      logic              unused_s_valid;
      logic [DATA_W-1:0] m_d;
      logic [DATA_W-1:0] s_q;

      // in_ready comes straight from a flop
      always_ff @(posedge clock) begin
        if (reset) begin
          state <= EMPTY;
          rdy_q <= 1'b1;
        end else begin
          state <= nxt;
          rdy_q <= (nxt != FULL);
        end
      end

      always_comb begin
        nxt         = state;
        m_load      = 1'b0;
        m_clr       = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        s_clr       = 1'b0;
        if (flush) begin
          nxt   = EMPTY;
          m_clr = 1'b1;
          s_clr = 1'b1;
        end else begin
          unique case (state)
            EMPTY: begin
              if (push) begin
                nxt    = ONE;
                m_load = 1'b1;
              end
            end
            ONE: begin
              if (push) begin
                m_load = pop;
                s_load = ~pop;
                nxt    = pop ? ONE : FULL;
              end else if (pop) begin
                nxt   = EMPTY;
                m_clr = 1'b1;
              end
            end
            FULL: begin
              if (pop) begin
                nxt         = ONE;
                m_load      = 1'b1;
                m_from_skid = 1'b1;
                s_clr       = 1'b1;
              end
            end
            default: nxt = EMPTY;
          endcase
        end
      end

      assign m_d = m_from_skid ? s_q : in_data;

      pipe_slot #(.DATA_W(DATA_W)) u_main (
        .clock (clock),
        .reset (reset),
        .load  (m_load),
        .clear (m_clr),
        .d     (m_d),
        .valid (out_valid),
        .q     (out_data)
      );

      pipe_slot #(.DATA_W(DATA_W)) u_skid (
        .clock (clock),
        .reset (reset),
        .load  (s_load),
        .clear (s_clr),
        .d     (in_data),
        .valid (s_valid),
        .q     (s_q)
      );

      // skid occupancy is implied by state FULL
      assign unused_s_valid = s_valid;
      assign in_ready       = rdy_q;
    end else begin : g_plain
      assign in_ready = ~out_valid | out_ready;

      pipe_slot #(.DATA_W(DATA_W)) u_main (
        .clock (clock),
        .reset (reset),
        .load  (push),
        .clear (flush | (pop & ~push)),
        .d     (in_data),
        .valid (out_valid),
        .q     (out_data)
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush
                 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register. It replaces the fixed-field EXE/MEM-style latches with a single valid/ready handshaked stage.
- Carries an opaque DATA_W-bit bundle: PC, operands, destination register, control bits.
- Supports stall (back-pressure), flush (bubble insertion), and an optional 2-entry skid buffer. The skid buffer makes in_ready register-driven.
- Instantiated between every pair of stages of the 5-stage pipeline.

Parameters:
- DATA_W, 105, width of the payload bundle. Default is pc+b+c+num_write+control.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries and the current input this cycle.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept a payload.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds a valid payload.
- out_ready  in  1  downstream accepts the payload.
- out_data  out  DATA_W  payload to downstream; all-zero when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Clock and reset: one clock is used. Reset is synchronous and active-high; the ports are named clock and reset.
- Reset values:
  - out_valid=0, out_data=0, stall_cnt=0.
  - Internal skid entry invalid and zero.
  - in_ready=1 (SKID=1).
  - Inputs are ignored during the reset cycle.
- Handshake definitions:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready.
  - Upstream is expected to hold in_data stable while in_valid=1 and in_ready=0.
- SKID=1 state machine, states EMPTY / ONE / FULL:
  - EMPTY:
    - push -> ONE; main register loads in_data.
  - ONE:
    - push & pop -> ONE; main loads in_data.
    - push & ~pop -> FULL; skid loads in_data.
    - ~push & pop -> EMPTY; main is zeroed.
    - Otherwise hold.
  - FULL:
    - pop -> ONE; main loads skid, skid is zeroed.
    - in_ready=0, so no push is possible.
    - ~pop -> hold.
  - Output mapping: out_valid = (state != EMPTY). in_ready = (state != FULL); it is driven directly from a state flop.
- SKID=0:
  - Single register.
  - in_ready = ~out_valid | out_ready (combinational).
  - push loads the register. pop & ~push clears it to zero.
- Latency: one cycle from push to out_valid in both modes. No combinational path from in_data to out_data.
- Throughput: one payload per cycle while out_ready=1.
- flush=1:
  - Next state is EMPTY; all entries are zeroed and invalid.
  - The current input is dropped, even if in_valid & in_ready.
  - A pop in the same cycle still completes, since downstream already sampled out_data.
  - in_ready=1 in the following cycle.
- reset and flush together: reset wins. The result is identical except that stall_cnt is also cleared.
- Bubble semantics: invalid slots carry all-zero data, so every write-enable inside the bundle reads 0.
- stall_cnt:
  - Increments when out_valid & ~out_ready & ~flush.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Ordering: strict FIFO order. No payload is duplicated or lost except by flush.

Decomposition:
- Shared package pipe_pkg holds:
  - Stage-state encoding constants: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
  - Default bundle widths: PC_W=32, REG_NUM_W=5, S_DATA_W=2.
  - Helper constant for the EXE/MEM bundle width (105).
- One natural sub-module: pipe_slot. It is a single valid+data register with load/clear/hold controls and zero-on-clear. pipe_slot is instantiated twice for SKID=1 (main, skid) and once for SKID=0.

Test Plan:
1. Reset, then in_valid=1 with in_data=0xA5 and out_ready=1 held -> out_valid=1 and out_data=0xA5 one cycle later; in_ready stays 1; stall_cnt=0.
2. SKID=1: hold out_ready=0 and push 0x11 then 0x22 -> in_ready=0 after the second push and stall_cnt increments each cycle. Raise out_ready -> 0x11 then 0x22 delivered on consecutive cycles, then out_valid=0 and out_data=0.
3. Streaming 100 incrementing payloads with out_ready toggling pseudo-randomly -> all 100 received in order with no duplicates, in both SKID=0 and SKID=1.
4. FULL state with in_valid=1, then flush=1 for one cycle -> next cycle out_valid=0, out_data=0, in_ready=1, and the flushed payloads never appear.
5. Assert reset mid-stream in the FULL state -> next cycle all outputs equal their reset values and stall_cnt=0. The first post-reset push appears after one cycle.
6. CNT_W=4 with out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt saturates at 15 and does not wrap.
